// File: rtl/decode_req_queue.sv
// Circular FIFO of decode requests between fetch and decode, flushed on mispredict redirect.
// Optional same-cycle empty-queue pass-through enabled by DECODE_QUEUE_BYPASS_EN.

package decode_req_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] predict_pc_addr;
    logic            predict_brunch_taken;
  } decode_require_t;
endpackage

module decode_req_queue
  import decode_req_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push_valid,
  output logic            push_ready,
  input  decode_require_t push_data,
  output logic            pop_valid,
  input  logic            pop_ready,
  output decode_require_t pop_data,
  output logic [PTR_W:0]  count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  decode_require_t  mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             empty_c;
  logic             full_c;
  logic             bypass_c;
  logic             push_fire_c;
  logic             pop_fire_c;
  logic             wr_en_c;
  logic             rd_en_c;

  assign wr_idx  = wr_ptr[PTR_W-1:0];
  assign rd_idx  = rd_ptr[PTR_W-1:0];
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_idx == rd_idx) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

`ifdef DECODE_QUEUE_BYPASS_EN
  assign bypass_c = empty_c && push_valid && !flush;
`else
  assign bypass_c = 1'b0;
`endif

  // push_ready deliberately ignores pop_ready: a full queue never accepts, even while popping.
  assign push_ready  = !full_c && !flush;
  assign pop_valid   = (!empty_c || bypass_c) && !flush;
  assign push_fire_c = push_valid && push_ready;
  assign pop_fire_c  = pop_valid && pop_ready;

  // A bypassed entry consumed in the same cycle never touches storage or pointers.
  assign wr_en_c = push_fire_c && !(bypass_c && pop_ready);
  assign rd_en_c = pop_fire_c && !bypass_c;

  // Head entry to the decoder; zero when nothing is stored.
  always_comb begin
    pop_data = '0;
    if (bypass_c) begin
      pop_data = push_data;
    end else if (!empty_c) begin
      pop_data = mem[rd_idx];
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_idx] <= push_data;
    end
  end

  // Pointers and occupancy count; flush dominates any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + CNT_W'(1);
      end
      if (rd_en_c) begin
        rd_ptr <= rd_ptr + CNT_W'(1);
      end
      case ({wr_en_c, rd_en_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
